// File: rtl/l1_cache_pkg.sv
// Shared types and address helpers for the L1 data cache controller.
package l1_cache_pkg;

  localparam int unsigned TAG_W      = 18;
  localparam int unsigned IDX_W      = 9;
  localparam int unsigned WORD_SEL_W = 3;
  localparam int unsigned LINE_W     = 256;
  localparam int unsigned ENTRY_W    = 275;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MISS = 2'd1,
    FILL = 2'd2
  } l1_state_e;

  function automatic logic [TAG_W-1:0] get_tag(input logic [31:0] addr);
    return addr[31:14];
  endfunction

  function automatic logic [IDX_W-1:0] get_idx(input logic [31:0] addr);
    return addr[13:5];
  endfunction

  function automatic logic [WORD_SEL_W-1:0] get_word(input logic [31:0] addr);
    return addr[4:2];
  endfunction

endpackage

// File: rtl/l1_cache_array.sv
// Valid/tag/data storage: async read, line-fill write, single-word write.
module l1_cache_array
  import l1_cache_pkg::*;
#(
  parameter int unsigned NUM_LINES = 512,
  parameter int unsigned TAG_W     = 18,
  parameter int unsigned IDX_BITS  = 9
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [IDX_BITS-1:0]   rd_idx_i,
  output logic                  rd_valid_o,
  output logic [TAG_W-1:0]      rd_tag_o,
  output logic [LINE_W-1:0]     rd_line_o,
  input  logic                  fill_we_i,
  input  logic [IDX_BITS-1:0]   fill_idx_i,
  input  logic                  fill_valid_i,
  input  logic [TAG_W-1:0]      fill_tag_i,
  input  logic [LINE_W-1:0]     fill_line_i,
  input  logic                  word_we_i,
  input  logic [IDX_BITS-1:0]   word_idx_i,
  input  logic [WORD_SEL_W-1:0] word_sel_i,
  input  logic [31:0]           word_data_i
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_mem [NUM_LINES];
  logic [LINE_W-1:0]    data_mem[NUM_LINES];

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_mem[rd_idx_i];
  assign rd_line_o  = data_mem[rd_idx_i];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (fill_we_i) begin
      valid_q[fill_idx_i] <= fill_valid_i;
    end
  end

  // Tag/data RAMs carry no reset; the valid vector alone qualifies them.
  always_ff @(posedge clk_i) begin
    if (fill_we_i) begin
      tag_mem[fill_idx_i]  <= fill_tag_i;
      data_mem[fill_idx_i] <= fill_line_i;
    end else if (word_we_i) begin
      data_mem[word_idx_i][{word_sel_i, 5'd0} +: 32] <= word_data_i;
    end
  end

endmodule

// File: rtl/l1_dcache_ctrl.sv
// Direct-mapped write-through L1 D-cache controller: lookup, hit service,
// miss hand-off to the miss handler and line install.
module l1_dcache_ctrl
  import l1_cache_pkg::*;
#(
  parameter int unsigned NUM_LINES = 512,
  parameter int unsigned TAG_W     = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cpu_rd_en,
  input  logic         cpu_wr_en,
  input  logic [31:0]  cpu_addr,
  input  logic [31:0]  cpu_wr_data,
  output logic [31:0]  cpu_rd_data,
  output logic         cpu_stall,
  output logic         rd_miss,
  output logic         wr_miss,
  output logic [31:0]  miss_addr,
  output logic [31:0]  wr_miss_data,
  input  logic [274:0] entry_upd_val,
  input  logic         upd_entry,
  output logic         wt_wr_en,
  output logic [31:0]  wt_addr,
  output logic [31:0]  wt_data
);

  localparam int unsigned IW = $clog2(NUM_LINES);

  l1_state_e   state_q, state_d;
  logic        rd_miss_q, rd_miss_d, wr_miss_q, wr_miss_d;
  logic [31:0] miss_addr_q, miss_addr_d, wr_miss_data_q, wr_miss_data_d;
  logic        wt_wr_en_q, wt_wr_en_d;
  logic [31:0] wt_addr_q, wt_addr_d, wt_data_q, wt_data_d;
  logic        was_wr_q, was_wr_d, skip_wr_q, skip_wr_d;

  logic [IW-1:0]         idx;
  logic [TAG_W-1:0]      tag;
  logic [WORD_SEL_W-1:0] wsel;
  logic                  rd_valid, hit, req, fill_en, word_we;
  logic [TAG_W-1:0]      rd_tag;
  logic [LINE_W-1:0]     rd_line;
  logic                  unused_addr_lsb;

  assign idx             = cpu_addr[5 +: IW];
  assign tag             = cpu_addr[31 -: TAG_W];
  assign wsel            = get_word(cpu_addr);
  assign unused_addr_lsb = ^cpu_addr[1:0];
  assign req             = cpu_rd_en | cpu_wr_en;
  assign hit             = rd_valid & (rd_tag == tag);
  assign cpu_rd_data     = hit ? rd_line[{wsel, 5'd0} +: 32] : '0;

  l1_cache_array #(
    .NUM_LINES (NUM_LINES),
    .TAG_W     (TAG_W),
    .IDX_BITS  (IW)
  ) u_array (
    .clk_i        (clk),
    .rst_i        (rst),
    .rd_idx_i     (idx),
    .rd_valid_o   (rd_valid),
    .rd_tag_o     (rd_tag),
    .rd_line_o    (rd_line),
    .fill_we_i    (fill_en & ~rst),
    .fill_idx_i   (miss_addr_q[5 +: IW]),
    .fill_valid_i (entry_upd_val[274]),
    .fill_tag_i   (entry_upd_val[273:256]),
    .fill_line_i  (entry_upd_val[255:0]),
    .word_we_i    (word_we),
    .word_idx_i   (idx),
    .word_sel_i   (wsel),
    .word_data_i  (cpu_wr_data)
  );

  always_comb begin
    state_d        = state_q;
    rd_miss_d      = rd_miss_q;
    wr_miss_d      = wr_miss_q;
    miss_addr_d    = miss_addr_q;
    wr_miss_data_d = wr_miss_data_q;
    wt_wr_en_d     = 1'b0;
    wt_addr_d      = wt_addr_q;
    wt_data_d      = wt_data_q;
    was_wr_d       = was_wr_q;
    skip_wr_d      = 1'b0;
    cpu_stall      = 1'b0;
    fill_en        = 1'b0;
    word_we        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req && hit) begin
          // The replayed store after a store miss is already merged into the
          // installed line and known to L2, so it neither writes nor writes through.
          if (cpu_wr_en && !skip_wr_q) begin
            word_we    = 1'b1;
            wt_wr_en_d = 1'b1;
            wt_addr_d  = {2'b00, cpu_addr[31:2]};
            wt_data_d  = cpu_wr_data;
          end
        end else if (req) begin
          cpu_stall      = 1'b1;
          miss_addr_d    = cpu_addr;
          wr_miss_data_d = cpu_wr_data;
          rd_miss_d      = ~cpu_wr_en;
          wr_miss_d      = cpu_wr_en;
          was_wr_d       = cpu_wr_en;
          state_d        = MISS;
        end
      end
      MISS: begin
        cpu_stall = 1'b1;
        if (upd_entry) begin
          fill_en   = 1'b1;
          rd_miss_d = 1'b0;
          wr_miss_d = 1'b0;
          state_d   = FILL;
        end
      end
      FILL: begin
        cpu_stall = 1'b1;
        skip_wr_d = was_wr_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      rd_miss_q      <= 1'b0;
      wr_miss_q      <= 1'b0;
      miss_addr_q    <= '0;
      wr_miss_data_q <= '0;
      wt_wr_en_q     <= 1'b0;
      wt_addr_q      <= '0;
      wt_data_q      <= '0;
      was_wr_q       <= 1'b0;
      skip_wr_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      rd_miss_q      <= rd_miss_d;
      wr_miss_q      <= wr_miss_d;
      miss_addr_q    <= miss_addr_d;
      wr_miss_data_q <= wr_miss_data_d;
      wt_wr_en_q     <= wt_wr_en_d;
      wt_addr_q      <= wt_addr_d;
      wt_data_q      <= wt_data_d;
      was_wr_q       <= was_wr_d;
      skip_wr_q      <= skip_wr_d;
    end
  end

  assign rd_miss      = rd_miss_q;
  assign wr_miss      = wr_miss_q;
  assign miss_addr    = miss_addr_q;
  assign wr_miss_data = wr_miss_data_q;
  assign wt_wr_en     = wt_wr_en_q;
  assign wt_addr      = wt_addr_q;
  assign wt_data      = wt_data_q;

endmodule

// File: tb/tb_l1_dcache_ctrl.sv
// Directed self-checking bench for l1_dcache_ctrl.
module tb_l1_dcache_ctrl;

  logic         clk;
  logic         rst;
  logic         cpu_rd_en, cpu_wr_en;
  logic [31:0]  cpu_addr, cpu_wr_data, cpu_rd_data;
  logic         cpu_stall, rd_miss, wr_miss;
  logic [31:0]  miss_addr, wr_miss_data;
  logic [274:0] entry_upd_val;
  logic         upd_entry;
  logic         wt_wr_en;
  logic [31:0]  wt_addr, wt_data;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  l1_dcache_ctrl #(
    .NUM_LINES (512),
    .TAG_W     (18)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_rd_en     (cpu_rd_en),
    .cpu_wr_en     (cpu_wr_en),
    .cpu_addr      (cpu_addr),
    .cpu_wr_data   (cpu_wr_data),
    .cpu_rd_data   (cpu_rd_data),
    .cpu_stall     (cpu_stall),
    .rd_miss       (rd_miss),
    .wr_miss       (wr_miss),
    .miss_addr     (miss_addr),
    .wr_miss_data  (wr_miss_data),
    .entry_upd_val (entry_upd_val),
    .upd_entry     (upd_entry),
    .wt_wr_en      (wt_wr_en),
    .wt_addr       (wt_addr),
    .wt_data       (wt_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [274:0] mk_entry(input logic [17:0] t, input logic [31:0] w0,
                                            input logic [31:0] w1, input logic [31:0] w2);
    logic [274:0] e;
    e          = '0;
    e[274]     = 1'b1;
    e[273:256] = t;
    e[31:0]    = w0;
    e[63:32]   = w1;
    e[95:64]   = w2;
    return e;
  endfunction

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    cpu_rd_en   = rd;
    cpu_wr_en   = wr;
    cpu_addr    = a;
    cpu_wr_data = d;
    #1;
  endtask

  task automatic pulse_fill(input logic [274:0] e);
    entry_upd_val = e;
    upd_entry     = 1'b1;
    tick();
    upd_entry     = 1'b0;
  endtask

  initial begin
    rst = 1'b1; upd_entry = 1'b0; entry_upd_val = '0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_stall", {31'd0, cpu_stall}, 32'd0);
    check("rst_rd_miss", {31'd0, rd_miss}, 32'd0);
    check("rst_wr_miss", {31'd0, wr_miss}, 32'd0);
    check("rst_wt_wr_en", {31'd0, wt_wr_en}, 32'd0);
    check("rst_miss_addr", miss_addr, 32'h0);
    check("rst_wt_addr", wt_addr, 32'h0);
    check("rst_rd_data", cpu_rd_data, 32'h0);

    // Cold load miss, fill with tag 1
    drive(1'b1, 1'b0, 32'h0000_4020, 32'h0);
    check("miss1_stall_comb", {31'd0, cpu_stall}, 32'd1);
    tick();
    check("miss1_rd_miss", {31'd0, rd_miss}, 32'd1);
    check("miss1_addr", miss_addr, 32'h0000_4020);
    check("miss1_stall_held", {31'd0, cpu_stall}, 32'd1);
    tick();
    check("miss1_rd_miss_held", {31'd0, rd_miss}, 32'd1);
    pulse_fill(mk_entry(18'h00001, 32'hDEAD_BEEF, 32'h1111_0001, 32'h2222_0002));
    check("fill1_stall", {31'd0, cpu_stall}, 32'd1);
    check("fill1_rd_miss_clr", {31'd0, rd_miss}, 32'd0);
    tick();
    check("fill1_stall_drop", {31'd0, cpu_stall}, 32'd0);
    check("fill1_data", cpu_rd_data, 32'hDEAD_BEEF);

    // Hit on w1
    drive(1'b1, 1'b0, 32'h0000_4024, 32'h0);
    check("hit_w1_stall", {31'd0, cpu_stall}, 32'd0);
    check("hit_w1_data", cpu_rd_data, 32'h1111_0001);
    tick();

    // Store hit with write-through, then load-after-store
    drive(1'b0, 1'b1, 32'h0000_4028, 32'h1234_5678);
    check("st_hit_stall", {31'd0, cpu_stall}, 32'd0);
    tick();
    check("wt_en", {31'd0, wt_wr_en}, 32'd1);
    check("wt_addr", wt_addr, 32'h0000_100A);
    check("wt_data", wt_data, 32'h1234_5678);
    drive(1'b1, 1'b0, 32'h0000_4028, 32'h0);
    check("ld_after_st", cpu_rd_data, 32'h1234_5678);
    check("ld_after_st_stall", {31'd0, cpu_stall}, 32'd0);
    tick();
    check("wt_en_one_cycle", {31'd0, wt_wr_en}, 32'd0);

    // Conflict miss at index 1 with tag 2
    drive(1'b1, 1'b0, 32'h0000_8020, 32'h0);
    check("conf_stall", {31'd0, cpu_stall}, 32'd1);
    tick();
    check("conf_addr", miss_addr, 32'h0000_8020);
    tick(); tick();
    check("conf_rd_miss_held", {31'd0, rd_miss}, 32'd1);
    pulse_fill(mk_entry(18'h00002, 32'hCAFE_0002, 32'h0, 32'h0));
    tick();
    check("conf_data", cpu_rd_data, 32'hCAFE_0002);
    drive(1'b1, 1'b0, 32'h0000_4020, 32'h0);
    check("evicted_miss", {31'd0, cpu_stall}, 32'd1);
    tick();
    pulse_fill(mk_entry(18'h00001, 32'hDEAD_BEEF, 32'h1111_0001, 32'h2222_0002));
    tick();
    check("refill_data", cpu_rd_data, 32'hDEAD_BEEF);

    // Store miss: no write-through after install
    drive(1'b0, 1'b1, 32'h0000_C000, 32'hA5A5_A5A5);
    check("stm_stall", {31'd0, cpu_stall}, 32'd1);
    tick();
    check("stm_wr_miss", {31'd0, wr_miss}, 32'd1);
    check("stm_rd_miss", {31'd0, rd_miss}, 32'd0);
    check("stm_data", wr_miss_data, 32'hA5A5_A5A5);
    pulse_fill(mk_entry(18'h00003, 32'hA5A5_A5A5, 32'h0, 32'h0));
    check("stm_wr_miss_clr", {31'd0, wr_miss}, 32'd0);
    check("stm_fill_wt", {31'd0, wt_wr_en}, 32'd0);
    tick();
    check("stm_stall_drop", {31'd0, cpu_stall}, 32'd0);
    tick();
    check("stm_no_wt", {31'd0, wt_wr_en}, 32'd0);

    // Back-to-back hits on different lines
    drive(1'b1, 1'b0, 32'h0000_C000, 32'h0);
    check("b2b_a_stall", {31'd0, cpu_stall}, 32'd0);
    check("b2b_a_data", cpu_rd_data, 32'hA5A5_A5A5);
    tick();
    drive(1'b1, 1'b0, 32'h0000_4024, 32'h0);
    check("b2b_b_stall", {31'd0, cpu_stall}, 32'd0);
    check("b2b_b_data", cpu_rd_data, 32'h1111_0001);
    tick();

    // upd_entry outside MISS is ignored
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    pulse_fill(mk_entry(18'h00005, 32'h5555_5555, 32'h0, 32'h0));
    drive(1'b1, 1'b0, 32'h0001_4040, 32'h0);
    check("stray_upd_miss", {31'd0, cpu_stall}, 32'd1);
    tick();
    check("stray_rd_miss", {31'd0, rd_miss}, 32'd1);

    // Reset in MISS, with a fill pulse in the same cycle
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    pulse_fill(mk_entry(18'h00005, 32'h5555_5555, 32'h0, 32'h0));
    rst = 1'b0;
    #1;
    check("rstm_rd_miss", {31'd0, rd_miss}, 32'd0);
    check("rstm_idle_stall", {31'd0, cpu_stall}, 32'd0);
    drive(1'b1, 1'b0, 32'h0000_4020, 32'h0);
    check("rstm_line1_inv", {31'd0, cpu_stall}, 32'd1);
    drive(1'b1, 1'b0, 32'h0000_C000, 32'h0);
    check("rstm_line0_inv", {31'd0, cpu_stall}, 32'd1);
    drive(1'b1, 1'b0, 32'h0001_4040, 32'h0);
    check("rstm_upd_dropped", {31'd0, cpu_stall}, 32'd1);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("rstm_no_miss", {31'd0, rd_miss}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
